coreboard1588_pps_gen: RTL and testbench
========================================

Name: coreboard1588_pps_gen

Overview:
- Timed-pulse transmitter driven by the local RTC (`rtc_second` / `rtc_nanosecond`, `clk` domain).
- Generates a PPS output aligned to every second rollover.
- Generates a programmable pulse train that starts at an armed absolute RTC time. It is the transmit-side counterpart of the PPS receive path and drives the board PPS/trigger pins.
- Control comes from the register block; status feeds back to it.

Parameters:
- C_CNT_WIDTH, 32: width of the cycle counters (high time, period, pulse count).
- C_PPS_DEFAULT_WIDTH, 10000000: PPS high time in clk cycles used when `ctrl_pps_width` is 0.

Ports:
- clk  in  1  system clock, the same clock as the RTC.
- rst  in  1  reset; asynchronous, active-high.
- rtc_second  in  32  current RTC seconds; updates in clk.
- rtc_nanosecond  in  32  current RTC nanoseconds, 0..999999999.
- ctrl_pps_enable  in  1  enables pps_out generation.
- ctrl_pps_width  in  C_CNT_WIDTH  PPS high time in cycles; 0 selects C_PPS_DEFAULT_WIDTH.
- ctrl_arm  in  1  single-cycle pulse; arms the pulse train.
- ctrl_abort  in  1  single-cycle pulse; stops the train.
- ctrl_start_second  in  32  train start time, seconds.
- ctrl_start_nanosecond  in  32  train start time, nanoseconds.
- ctrl_high_cycles  in  C_CNT_WIDTH  train pulse high time in cycles.
- ctrl_period_cycles  in  C_CNT_WIDTH  train period in cycles.
- ctrl_pulse_count  in  C_CNT_WIDTH  number of pulses; 0 means infinite.
- pps_out  out  1  PPS output.
- trig_out  out  1  pulse-train output.
- stat_busy  out  1  high in ARMED, HIGH and LOW.
- stat_late  out  1  sticky; start time had already passed when the match fired.
- stat_done  out  1  single-cycle pulse at train completion or abort.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. All counters 0. The previous-second register loads `rtc_second` on the first cycle after reset; no PPS pulse is generated for that load.

PPS:
- sec_chg = `rtc_second` differs from its registered previous value. A jump caused by a timeset also counts.
- On sec_chg with `ctrl_pps_enable` = 1: pps_out goes to 1 on the next cycle (latency 1) and stays high for W cycles. W = `ctrl_pps_width`, or C_PPS_DEFAULT_WIDTH if that is 0.
- sec_chg while pps_out is already high restarts the W count.
- `ctrl_pps_enable` = 0 forces pps_out to 0 on the next cycle and clears the counter.

Train parameters:
- Latched when ARMED is entered.
- Effective period P = max(`ctrl_period_cycles`, 2).
- Effective high time H = clamp(`ctrl_high_cycles`, 1, P-1).
- N = `ctrl_pulse_count`.

Train FSM:
- IDLE: `ctrl_arm` latches the start time, P, H and N, clears stat_late, and moves to ARMED.
- ARMED:
  - Each cycle, evaluate match = (rtc_sec > start_sec) or (rtc_sec == start_sec and rtc_ns >= start_ns). The comparison is unsigned and registered.
  - On match, go to HIGH; trig_out rises 1 cycle after the match cycle.
  - If match is true on the first comparison after arming and rtc is strictly past the start time, set stat_late.
- HIGH: trig_out = 1 for H cycles, then go to LOW.
- LOW:
  - trig_out = 0 for P-H cycles, then decrement the remaining count.
  - If N was nonzero and the remaining count reaches 0: go to IDLE and pulse stat_done.
  - Otherwise go back to HIGH.
- Abort: `ctrl_abort` in any non-IDLE state puts the FSM in IDLE on the next cycle, trig_out = 0, and pulses stat_done. In IDLE, `ctrl_abort` is a no-op.

Boundary rules:
- `ctrl_arm` while busy is ignored.
- Simultaneous arm and abort in IDLE: arm wins.
- Simultaneous arm and abort while busy: abort wins.
- An RTC timeset while ARMED is honoured by the next comparison.
- An RTC timeset while in HIGH or LOW does not disturb cycle counting.
- Asynchronous rst mid-train: trig_out and pps_out go to 0 immediately, the FSM returns to IDLE, and stat_done is not pulsed.

Test Plan:
1. PPS width: enable = 1, width = 5; rtc_second steps 7 -> 8 at cycle 100. Required: pps_out high during cycles 101-105, low at 106. Then width = 0. Required: the next pulse lasts C_PPS_DEFAULT_WIDTH cycles.
2. Scheduled train: start = 10 s / 500 ns; rtc at 10 s / 0 ns advancing 8 ns per cycle; H = 3, P = 10, N = 4; arm. Required: first rise on the cycle after ns >= 500; exactly 4 pulses, each 3 high / 7 low; stat_done pulses once; stat_late = 0.
3. Late start: arm with start = 5 s / 0 ns while rtc = 6 s / 0 ns. Required: trig_out rises 2 cycles after arm (latch, then registered compare) and stat_late = 1.
4. Clamping and infinite count: H = 20, P = 1, N = 0. Required: effective P = 2, H = 1, giving a continuous 1/1 toggle. Abort after 50 cycles. Required: trig_out = 0 and stat_done = 1 on the next cycle; stat_busy = 0.
5. Arm while busy: arm again mid-train with different P. Required: the train timing is unchanged.
6. PPS restart: a second rollover while pps_out is high with width 1000 and a forced timeset after 10 cycles. Required: the pulse extends to 1000 cycles after the second change.
7. Reset in HIGH. Required: both outputs 0 asynchronously and no stat_done pulse.

Source files
------------

// File: rtl/coreboard1588_pps_gen_if.sv
// RTC / register-block bundle for the timed-pulse transmitter.
// The master side is the register block plus RTC; the slave side is the pulse generator.
interface coreboard1588_pps_gen_if #(
    parameter int unsigned C_CNT_WIDTH = 32
);
    logic [31:0]            rtc_second;
    logic [31:0]            rtc_nanosecond;
    logic                   ctrl_pps_enable;
    logic [C_CNT_WIDTH-1:0] ctrl_pps_width;
    logic                   ctrl_arm;
    logic                   ctrl_abort;
    logic [31:0]            ctrl_start_second;
    logic [31:0]            ctrl_start_nanosecond;
    logic [C_CNT_WIDTH-1:0] ctrl_high_cycles;
    logic [C_CNT_WIDTH-1:0] ctrl_period_cycles;
    logic [C_CNT_WIDTH-1:0] ctrl_pulse_count;
    logic                   pps_out;
    logic                   trig_out;
    logic                   stat_busy;
    logic                   stat_late;
    logic                   stat_done;

    modport master (
        output rtc_second, rtc_nanosecond,
        output ctrl_pps_enable, ctrl_pps_width,
        output ctrl_arm, ctrl_abort,
        output ctrl_start_second, ctrl_start_nanosecond,
        output ctrl_high_cycles, ctrl_period_cycles, ctrl_pulse_count,
        input  pps_out, trig_out, stat_busy, stat_late, stat_done
    );

    modport slave (
        input  rtc_second, rtc_nanosecond,
        input  ctrl_pps_enable, ctrl_pps_width,
        input  ctrl_arm, ctrl_abort,
        input  ctrl_start_second, ctrl_start_nanosecond,
        input  ctrl_high_cycles, ctrl_period_cycles, ctrl_pulse_count,
        output pps_out, trig_out, stat_busy, stat_late, stat_done
    );
endinterface

// File: rtl/coreboard1588_pps_gen.sv
// Timed-pulse transmitter: PPS aligned to RTC second rollovers plus a
// programmable pulse train launched at an armed absolute RTC time.
module coreboard1588_pps_gen #(
    parameter int unsigned C_CNT_WIDTH         = 32,
    parameter int unsigned C_PPS_DEFAULT_WIDTH = 10000000
) (
    input  logic                    clk,
    input  logic                    rst,
    coreboard1588_pps_gen_if.slave  bus
);

    localparam int unsigned     CW        = C_CNT_WIDTH;
    localparam logic [CW-1:0]   PPS_DEF_W = CW'(C_PPS_DEFAULT_WIDTH);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_TWO   = CW'(2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    // ---------------------------------------------------------------- PPS
    logic [31:0]   prev_sec_q, prev_sec_d;
    logic          init_q, init_d;
    logic          pps_q, pps_d;
    logic [CW-1:0] pps_cnt_q, pps_cnt_d;
    logic          sec_chg_c;
    logic [CW-1:0] pps_w_c;

    // PPS next state: second change (re)starts the pulse, counter holds remaining high cycles
    always_comb begin
        prev_sec_d = bus.rtc_second;
        init_d     = 1'b1;
        pps_d      = pps_q;
        pps_cnt_d  = pps_cnt_q;
        sec_chg_c  = init_q && (bus.rtc_second != prev_sec_q);
        pps_w_c    = (bus.ctrl_pps_width == '0) ? PPS_DEF_W : bus.ctrl_pps_width;
        if (!bus.ctrl_pps_enable) begin
            pps_d     = 1'b0;
            pps_cnt_d = '0;
        end else if (sec_chg_c) begin
            pps_d     = 1'b1;
            pps_cnt_d = pps_w_c - CNT_ONE;
        end else if (pps_q) begin
            if (pps_cnt_q == '0) begin
                pps_d = 1'b0;
            end else begin
                pps_cnt_d = pps_cnt_q - CNT_ONE;
            end
        end
    end

    // PPS registers; the first post-reset cycle only primes prev_sec
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sec_q <= '0;
            init_q     <= 1'b0;
            pps_q      <= 1'b0;
            pps_cnt_q  <= '0;
        end else begin
            prev_sec_q <= prev_sec_d;
            init_q     <= init_d;
            pps_q      <= pps_d;
            pps_cnt_q  <= pps_cnt_d;
        end
    end

    // -------------------------------------------------------------- train
    logic [1:0]    state_q, state_d;
    logic [31:0]   start_sec_q, start_sec_d;
    logic [31:0]   start_ns_q, start_ns_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] num_q, num_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    logic          trig_q, trig_d;
    logic          busy_q, busy_d;
    logic          late_q, late_d;
    logic          done_q, done_d;
    logic [CW-1:0] eff_per_c;
    logic [CW-1:0] eff_high_c;
    logic          match_c;
    logic          past_c;

    // Effective period/high time from the live control fields (latched on arm)
    always_comb begin
        eff_per_c = (bus.ctrl_period_cycles < CNT_TWO) ? CNT_TWO : bus.ctrl_period_cycles;
        if (bus.ctrl_high_cycles == '0) begin
            eff_high_c = CNT_ONE;
        end else if (bus.ctrl_high_cycles > (eff_per_c - CNT_ONE)) begin
            eff_high_c = eff_per_c - CNT_ONE;
        end else begin
            eff_high_c = bus.ctrl_high_cycles;
        end
    end

    // Unsigned RTC-vs-start compare; past_c distinguishes a strictly late start
    always_comb begin
        match_c = (bus.rtc_second > start_sec_q) ||
                  ((bus.rtc_second == start_sec_q) && (bus.rtc_nanosecond >= start_ns_q));
        past_c  = (bus.rtc_second > start_sec_q) ||
                  ((bus.rtc_second == start_sec_q) && (bus.rtc_nanosecond > start_ns_q));
    end

    // Train FSM next state and registered outputs
    always_comb begin
        state_d     = state_q;
        start_sec_d = start_sec_q;
        start_ns_d  = start_ns_q;
        per_d       = per_q;
        high_d      = high_q;
        num_d       = num_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        trig_d      = trig_q;
        late_d      = late_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                trig_d = 1'b0;
                if (bus.ctrl_arm) begin
                    start_sec_d = bus.ctrl_start_second;
                    start_ns_d  = bus.ctrl_start_nanosecond;
                    per_d       = eff_per_c;
                    high_d      = eff_high_c;
                    num_d       = bus.ctrl_pulse_count;
                    rem_d       = bus.ctrl_pulse_count;
                    late_d      = 1'b0;
                    first_d     = 1'b1;
                    state_d     = S_ARMED;
                end
            end
            S_ARMED: begin
                first_d = 1'b0;
                if (match_c) begin
                    state_d = S_HIGH;
                    trig_d  = 1'b1;
                    cnt_d   = high_q - CNT_ONE;
                    if (first_q && past_c) begin
                        late_d = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    trig_d  = 1'b0;
                    cnt_d   = per_q - high_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    if ((num_q != '0) && (rem_q == CNT_ONE)) begin
                        state_d = S_IDLE;
                        rem_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_HIGH;
                        trig_d  = 1'b1;
                        cnt_d   = high_q - CNT_ONE;
                        if (num_q != '0) begin
                            rem_d = rem_q - CNT_ONE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                trig_d  = 1'b0;
            end
        endcase

        // Abort overrides everything that happens in a busy state, including a late flag
        if ((state_q != S_IDLE) && bus.ctrl_abort) begin
            state_d = S_IDLE;
            trig_d  = 1'b0;
            cnt_d   = '0;
            late_d  = late_q;
            done_d  = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // Train registers; async reset drops the outputs without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_sec_q <= '0;
            start_ns_q  <= '0;
            per_q       <= '0;
            high_q      <= '0;
            num_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            late_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_sec_q <= start_sec_d;
            start_ns_q  <= start_ns_d;
            per_q       <= per_d;
            high_q      <= high_d;
            num_q       <= num_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            late_q      <= late_d;
            done_q      <= done_d;
        end
    end

    assign bus.pps_out   = pps_q;
    assign bus.trig_out  = trig_q;
    assign bus.stat_busy = busy_q;
    assign bus.stat_late = late_q;
    assign bus.stat_done = done_q;

endmodule

// File: tb/tb_coreboard1588_pps_gen.sv
// Bench for coreboard1588_pps_gen: directed + randomized stimulus against a
// cycle-indexed reference model (pulse windows computed arithmetically).
`timescale 1ns/1ps
module tb_coreboard1588_pps_gen;

    localparam int unsigned CW    = 32;
    localparam int unsigned DEF_W = 40;
    localparam int          BIG   = 1000000000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    coreboard1588_pps_gen_if #(.C_CNT_WIDTH(CW)) bus ();

    coreboard1588_pps_gen #(
        .C_CNT_WIDTH         (CW),
        .C_PPS_DEFAULT_WIDTH (DEF_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // PPS model: pulse covers cycles (pps_last, pps_last + pps_w]
    bit          pps_started;
    int unsigned pps_prev;
    int          pps_last;
    int          pps_w;

    // Train model: pulse k occupies [rise + k*P, rise + k*P + H)
    bit          tr_valid;
    int          arm_cyc, rise, end_cyc;
    int          m_p, m_h, m_n;
    int unsigned m_ss, m_sn;
    bit          late_cur, late_nxt;

    bit          rtc_run;
    int unsigned rtc_inc;

    int rises, dones, first_rise, match_cyc, c0;
    bit prevt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit exp_pps(input int t);
        return (pps_last >= 0) && (t > pps_last) && (t <= pps_last + pps_w);
    endfunction

    function automatic bit exp_busy(input int t);
        return tr_valid && (t > arm_cyc) && (t < end_cyc);
    endfunction

    function automatic bit exp_trig(input int t);
        return tr_valid && (rise >= 0) && (t >= rise) && (t < end_cyc) && (((t - rise) % m_p) < m_h);
    endfunction

    function automatic bit exp_done(input int t);
        return tr_valid && (t == end_cyc);
    endfunction

    // Advance the model with the inputs presented during cycle `cyc`
    task automatic model_update();
        bit m, past;
        if (rst) begin
            pps_started = 1'b0;
            pps_last    = -1;
            tr_valid    = 1'b0;
            arm_cyc     = -1;
            rise        = -1;
            end_cyc     = BIG;
            late_nxt    = 1'b0;
            return;
        end
        if (!pps_started) begin
            pps_started = 1'b1;
        end else if (!bus.ctrl_pps_enable) begin
            pps_last = -1;
        end else if (bus.rtc_second != pps_prev) begin
            pps_last = cyc;
            pps_w    = (bus.ctrl_pps_width == 0) ? int'(DEF_W) : int'(bus.ctrl_pps_width);
        end
        pps_prev = bus.rtc_second;

        if (exp_busy(cyc)) begin
            if (bus.ctrl_abort) begin
                if (cyc + 1 < end_cyc) end_cyc = cyc + 1;
            end else if (rise < 0) begin
                m    = (bus.rtc_second > m_ss) || ((bus.rtc_second == m_ss) && (bus.rtc_nanosecond >= m_sn));
                past = (bus.rtc_second > m_ss) || ((bus.rtc_second == m_ss) && (bus.rtc_nanosecond > m_sn));
                if (m) begin
                    rise = cyc + 1;
                    if (m_n != 0) end_cyc = rise + m_n * m_p;
                    if ((cyc == arm_cyc + 1) && past) late_nxt = 1'b1;
                end
            end
        end else if (bus.ctrl_arm) begin
            tr_valid = 1'b1;
            arm_cyc  = cyc;
            rise     = -1;
            end_cyc  = BIG;
            m_p      = (bus.ctrl_period_cycles < 2) ? 2 : int'(bus.ctrl_period_cycles);
            if (bus.ctrl_high_cycles < 1)                 m_h = 1;
            else if (bus.ctrl_high_cycles > m_p - 1)      m_h = m_p - 1;
            else                                          m_h = int'(bus.ctrl_high_cycles);
            m_n      = int'(bus.ctrl_pulse_count);
            m_ss     = bus.ctrl_start_second;
            m_sn     = bus.ctrl_start_nanosecond;
            late_nxt = 1'b0;
        end
    endtask

    // One clock: update model, sample all outputs 1ns after the edge, advance RTC
    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        late_cur = late_nxt;
        chk1("pps_out",   bus.pps_out,   exp_pps(cyc));
        chk1("trig_out",  bus.trig_out,  exp_trig(cyc));
        chk1("stat_busy", bus.stat_busy, exp_busy(cyc));
        chk1("stat_done", bus.stat_done, exp_done(cyc));
        chk1("stat_late", bus.stat_late, late_cur);
        if (rtc_run) begin
            bus.rtc_nanosecond = bus.rtc_nanosecond + rtc_inc;
            if (bus.rtc_nanosecond >= 32'd1000000000) begin
                bus.rtc_nanosecond = bus.rtc_nanosecond - 32'd1000000000;
                bus.rtc_second     = bus.rtc_second + 32'd1;
            end
        end
    endtask

    task automatic set_train(input int unsigned h, input int unsigned p, input int unsigned n,
                             input int unsigned ss, input int unsigned sn);
        bus.ctrl_high_cycles      = h;
        bus.ctrl_period_cycles    = p;
        bus.ctrl_pulse_count      = n;
        bus.ctrl_start_second     = ss;
        bus.ctrl_start_nanosecond = sn;
    endtask

    task automatic arm_pulse();
        bus.ctrl_arm = 1'b1;
        cycle();
        bus.ctrl_arm = 1'b0;
    endtask

    // Run until the model's train has ended, counting rising edges and done pulses
    task automatic run_train(input int limit);
        rises = 0;
        dones = 0;
        prevt = bus.trig_out;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (bus.trig_out && !prevt) rises++;
            prevt = bus.trig_out;
            if (bus.stat_done) dones++;
            if (cyc > end_cyc + 2) break;
        end
        chk1("train_ended_busy", bus.stat_busy, 1'b0);
    endtask

    initial begin
        rst                   = 1'b1;
        bus.rtc_second        = 32'd7;
        bus.rtc_nanosecond    = 32'd0;
        bus.ctrl_pps_enable   = 1'b0;
        bus.ctrl_pps_width    = '0;
        bus.ctrl_arm          = 1'b0;
        bus.ctrl_abort        = 1'b0;
        set_train(0, 0, 0, 0, 0);
        rtc_run  = 1'b0;
        rtc_inc  = 8;
        late_cur = 1'b0;
        late_nxt = 1'b0;
        pps_prev = 0;
        pps_w    = 0;
        m_p = 2; m_h = 1; m_n = 0; m_ss = 0; m_sn = 0;

        // Reset state
        repeat (3) cycle();
        rst = 1'b0;
        repeat (3) cycle();

        // PPS width 5 on a 7 -> 8 rollover
        bus.ctrl_pps_enable = 1'b1;
        bus.ctrl_pps_width  = 5;
        repeat (4) cycle();
        bus.rtc_second = 32'd8;
        c0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            chk1("pps_w5_window", bus.pps_out, (cyc - c0 >= 1) && (cyc - c0 <= 5));
        end

        // Width 0 selects the default width
        bus.ctrl_pps_width = 0;
        bus.rtc_second     = 32'd9;
        c0 = cyc;
        for (int i = 1; i <= int'(DEF_W) + 3; i++) begin
            cycle();
            chk1("pps_default_window", bus.pps_out, (cyc - c0) <= int'(DEF_W));
        end

        // Random widths
        for (int k = 0; k < 4; k++) begin
            bus.ctrl_pps_width = $urandom_range(1, 20);
            bus.rtc_second     = bus.rtc_second + 32'd1;
            repeat (int'(bus.ctrl_pps_width) + 3) cycle();
        end

        // Disable mid-pulse forces low on the next cycle
        bus.ctrl_pps_width = 10;
        bus.rtc_second     = bus.rtc_second + 32'd1;
        repeat (3) cycle();
        bus.ctrl_pps_enable = 1'b0;
        cycle();
        chk1("pps_disable", bus.pps_out, 1'b0);
        bus.ctrl_pps_enable = 1'b1;
        repeat (3) cycle();

        // Scheduled train at 10 s / 500 ns, 8 ns per cycle
        bus.ctrl_pps_width = 4;
        bus.rtc_second     = 32'd10;
        bus.rtc_nanosecond = 32'd0;
        rtc_inc = 8;
        rtc_run = 1'b1;
        set_train(3, 10, 4, 10, 500);
        arm_pulse();
        first_rise = -1;
        match_cyc  = -1;
        rises = 0; dones = 0; prevt = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (bus.trig_out && !prevt) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
            end
            prevt = bus.trig_out;
            if (bus.stat_done) dones++;
            if (match_cyc < 0 && bus.rtc_nanosecond >= 32'd500) match_cyc = cyc;
            if (cyc > end_cyc + 2) break;
        end
        chk32("t2_first_rise", first_rise, match_cyc + 1);
        chk32("t2_pulses", rises, 4);
        chk32("t2_done_pulses", dones, 1);
        chk1("t2_late", bus.stat_late, 1'b0);

        // Late start: rises two cycles after arm and sets stat_late
        rtc_run = 1'b0;
        bus.rtc_second     = 32'd6;
        bus.rtc_nanosecond = 32'd0;
        set_train(2, 4, 2, 5, 0);
        c0 = cyc;
        arm_pulse();
        chk1("t3_no_rise_yet", bus.trig_out, 1'b0);
        cycle();
        chk32("t3_rise_delay", cyc - c0, 2);
        chk1("t3_rise", bus.trig_out, 1'b1);
        chk1("t3_late", bus.stat_late, 1'b1);
        run_train(100);

        // Clamp to 1/1 toggle, infinite, abort after 50 cycles (start == now, not late)
        set_train(20, 1, 0, 6, 0);
        arm_pulse();
        repeat (50) cycle();
        chk1("t4_not_late", bus.stat_late, 1'b0);
        prevt = bus.trig_out;
        cycle();
        chk1("t4_toggle", bus.trig_out, !prevt);
        bus.ctrl_abort = 1'b1;
        cycle();
        bus.ctrl_abort = 1'b0;
        chk1("t4_abort_trig", bus.trig_out, 1'b0);
        chk1("t4_abort_done", bus.stat_done, 1'b1);
        chk1("t4_abort_busy", bus.stat_busy, 1'b0);
        repeat (3) cycle();

        // Arm + abort together: arm wins in IDLE, abort wins when busy
        set_train(3, 5, 0, 6, 0);
        bus.ctrl_arm   = 1'b1;
        bus.ctrl_abort = 1'b1;
        cycle();
        bus.ctrl_arm   = 1'b0;
        bus.ctrl_abort = 1'b0;
        chk1("arm_abort_idle_busy", bus.stat_busy, 1'b1);
        repeat (6) cycle();
        bus.ctrl_arm   = 1'b1;
        bus.ctrl_abort = 1'b1;
        cycle();
        bus.ctrl_arm   = 1'b0;
        bus.ctrl_abort = 1'b0;
        chk1("arm_abort_busy_idle", bus.stat_busy, 1'b0);
        chk1("arm_abort_busy_done", bus.stat_done, 1'b1);
        repeat (3) cycle();

        // Arm while busy is ignored; RTC jump during HIGH/LOW does not disturb timing
        bus.rtc_second     = 32'd30;
        bus.rtc_nanosecond = 32'd0;
        rtc_inc = 10;
        rtc_run = 1'b1;
        set_train(2, 6, 3, 30, 100);
        arm_pulse();
        rises = 0; dones = 0; prevt = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (bus.trig_out && !prevt) rises++;
            prevt = bus.trig_out;
            if (bus.stat_done) dones++;
            bus.ctrl_arm = 1'b0;
            if (rise >= 0 && cyc == rise + 4) begin
                bus.ctrl_period_cycles = 3;
                bus.ctrl_high_cycles   = 1;
                bus.ctrl_arm           = 1'b1;
            end
            if (rise >= 0 && cyc == rise + 9) bus.rtc_second = bus.rtc_second + 32'd3;
            if (cyc > end_cyc + 2) break;
        end
        bus.ctrl_arm = 1'b0;
        chk32("t5_pulses", rises, 3);
        chk32("t5_done_pulses", dones, 1);

        // Timeset while ARMED is honoured by the next comparison
        rtc_run = 1'b0;
        bus.rtc_second     = 32'd40;
        bus.rtc_nanosecond = 32'd0;
        set_train(1, 3, 2, 50, 7);
        arm_pulse();
        repeat (5) cycle();
        chk1("timeset_still_low", bus.trig_out, 1'b0);
        bus.rtc_second     = 32'd50;
        bus.rtc_nanosecond = 32'd7;
        c0 = cyc;
        cycle();
        chk1("timeset_rise", bus.trig_out, 1'b1);
        run_train(100);
        chk1("timeset_not_late", bus.stat_late, 1'b0);

        // Randomized trains
        for (int k = 0; k < 4; k++) begin
            bus.rtc_second     = 32'd100 + 32'(k);
            bus.rtc_nanosecond = 32'd0;
            rtc_inc = $urandom_range(1, 20);
            rtc_run = 1'b1;
            set_train($urandom_range(0, 8), $urandom_range(0, 12), $urandom_range(1, 4),
                      100 + k, $urandom_range(0, 400));
            arm_pulse();
            run_train(600);
        end
        rtc_run = 1'b0;

        // PPS restart: timeset while high extends the pulse from the new change
        bus.ctrl_pps_width = 1000;
        bus.rtc_second     = bus.rtc_second + 32'd1;
        repeat (10) cycle();
        bus.rtc_second = bus.rtc_second + 32'd5;
        c0 = cyc;
        for (int i = 1; i <= 1003; i++) begin
            cycle();
            if (i == 1000 || i == 1001) chk1("t6_pps_edge", bus.pps_out, i == 1000);
        end

        // Async reset in HIGH: outputs drop immediately, no done pulse
        bus.ctrl_pps_width = 50;
        bus.rtc_second     = bus.rtc_second + 32'd1;
        set_train(5, 8, 0, 0, 0);
        arm_pulse();
        cycle();
        cycle();
        chk1("t7_in_high", bus.trig_out, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("t7_async_trig", bus.trig_out, 1'b0);
        chk1("t7_async_pps", bus.pps_out, 1'b0);
        chk1("t7_async_busy", bus.stat_busy, 1'b0);
        chk1("t7_async_done", bus.stat_done, 1'b0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
